// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (both caches plus the memory) that drives the other end.
interface mem_arbiter_if #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
);
    // I-cache side (read-only)
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_busywait;

    // D-cache side (read and write-back)
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_busywait;

    // Main memory side
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    // Debug: current owner of the memory
    logic               grant_i;
    logic               grant_d;

    modport slave (
        input  i_read, i_address,
        output i_readdata, i_busywait,
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait,
        output grant_i, grant_d
    );

    modport master (
        output i_read, i_address,
        input  i_readdata, i_busywait,
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait,
        input  grant_i, grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide main memory between the I-cache
// (reads only) and the D-cache (reads and write-backs). One block transaction
// runs at a time; the memory command is registered and held until memory
// finishes, and the owner sees its busywait drop for exactly one cycle.
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    owner_t             last_q, last_d;
    owner_t             winner;
    logic               first_q, first_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
    logic               grant_i_q, grant_i_d;
    logic               grant_d_q, grant_d_d;
    logic               i_req, d_req;

    // A write-back and a read from the D-cache are one request; when both are
    // (illegally) raised the write wins, handled where the command is chosen.
    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // Round-robin pick: a tie goes to whoever did not own the last transfer.
    always_comb begin
        if (i_req && d_req) begin
            winner = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
    end

    // Next-state and next-register values for the whole transaction sequencer.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        first_d     = first_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i_d   = grant_i_q;
        grant_d_d   = grant_d_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d = winner;
                    first_d = 1'b1;
                    state_d = BUSY;
                    if (winner == OWN_I) begin
                        grant_i_d  = 1'b1;
                        addr_d     = bus.i_address;
                        mem_read_d = 1'b1;
                    end else begin
                        grant_d_d = 1'b1;
                        addr_d    = bus.d_address;
                        if (bus.d_write) begin
                            mem_write_d = 1'b1;
                            wdata_d     = bus.d_writedata;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end

            BUSY: begin
                // Memory busywait is not yet meaningful in the cycle the
                // command first appears, so the first BUSY cycle is skipped.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!bus.mem_busywait) begin
                    if (mem_read_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = bus.mem_readdata;
                        end else begin
                            i_rdata_d = bus.mem_readdata;
                        end
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_d      = owner_q;
                    state_d     = DONE;
                end
            end

            DONE: begin
                grant_i_d = 1'b0;
                grant_d_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            last_q      <= OWN_I;
            first_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            // NOTE: the wide address/data/readdata registers are reset too, since their post-reset zeros are visible to both caches and memory.
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            grant_i_q   <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            first_q     <= first_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            grant_i_q   <= grant_i_d;
            grant_d_q   <= grant_d_d;
        end
    end

    // Busywait stays high for any pending request except the owner's DONE cycle.
    assign bus.i_busywait = i_req & ~((state_q == DONE) && (owner_q == OWN_I));
    assign bus.d_busywait = d_req & ~((state_q == DONE) && (owner_q == OWN_D));

    assign bus.i_readdata    = i_rdata_q;
    assign bus.d_readdata    = d_rdata_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = addr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.grant_i       = grant_i_q;
    assign bus.grant_d       = grant_d_q;

    // Memory never sees a read and a write at once, and only one cache owns it.
    a_cmd_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(mem_read_q && mem_write_q));
    a_grant_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(grant_i_q && grant_d_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a bench-side memory with per-transfer
// latency, a transaction-timeline reference model compared every cycle, and
// directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;
    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- bench memory ----------------
    // Per-transfer settings chosen by the stimulus, latched when a command starts.
    int                 mem_n         = 2;
    logic               mem_first_low = 1'b0;
    logic [BLOCK_W-1:0] mem_data      = '0;
    int                 cur_n         = 2;
    logic               cur_first_low = 1'b0;
    logic [BLOCK_W-1:0] cur_data      = '0;
    int                 cnt           = 0;
    wire                cmd = bus.mem_read | bus.mem_write;

    // Count cycles since the command appeared; latch settings while idle.
    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else if (cmd) cnt <= cnt + 1;
        else cnt <= 0;
        if (!cmd) begin
            cur_n         <= mem_n;
            cur_first_low <= mem_first_low;
            cur_data      <= mem_data;
        end
    end

    assign bus.mem_busywait = cmd && ((cnt == 0) ? !cur_first_low : (cnt < cur_n));
    assign bus.mem_readdata = cur_data;

    // ---------------- reference model ----------------
    // Timeline view: a grant at edge G with memory latency N finishes at edge
    // G+N+1 (DONE), returns to idle at G+N+2 and may grant again at G+N+3.
    bit                 model_on = 1'b0;
    bit                 m_active = 1'b0;
    bit                 m_own_d  = 1'b0;
    bit                 m_last_d = 1'b0;
    bit                 m_write  = 1'b0;
    int                 m_done   = 0;
    logic [ADDR_W-1:0]  m_addr   = '0;
    logic [BLOCK_W-1:0] m_wdata  = '0;
    logic [BLOCK_W-1:0] m_rdata  = '0;
    logic [BLOCK_W-1:0] m_irdata = '0;
    logic [BLOCK_W-1:0] m_drdata = '0;

    always @(posedge clk) begin
        bit ireq, dreq;
        cyc++;
        ireq = bus.i_read;
        dreq = bus.d_read | bus.d_write;
        if (reset) begin
            m_active = 0; m_last_d = 0;
            m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        end else if (m_active) begin
            if (cyc == m_done) begin
                if (!m_write) begin
                    if (m_own_d) m_drdata = m_rdata;
                    else m_irdata = m_rdata;
                end
                m_last_d = m_own_d;
            end else if (cyc == m_done + 1) begin
                m_active = 0;
            end
        end else if (ireq || dreq) begin
            m_active = 1;
            m_own_d  = (ireq && dreq) ? !m_last_d : dreq;
            m_write  = m_own_d && bus.d_write;
            m_addr   = m_own_d ? bus.d_address : bus.i_address;
            if (m_write) m_wdata = bus.d_writedata;
            m_rdata  = mem_data;
            m_done   = cyc + mem_n + 1;
        end
        model_on = 1'b1;
    end

    // Compare every DUT output with the model away from the active edge.
    bit both_seen = 1'b0;
    always @(negedge clk) begin
        bit in_done, busy;
        if (model_on) begin
            in_done = m_active && (cyc == m_done);
            busy    = m_active && (cyc < m_done);
            if (bus.mem_read && bus.mem_write) both_seen = 1'b1;
            check("mem_read",      bus.mem_read,      busy && !m_write);
            check("mem_write",     bus.mem_write,     busy && m_write);
            check("mem_address",   bus.mem_address,   m_addr);
            check("mem_writedata", bus.mem_writedata, m_wdata);
            check("grant_i",       bus.grant_i,       m_active && !m_own_d);
            check("grant_d",       bus.grant_d,       m_active && m_own_d);
            check("i_readdata",    bus.i_readdata,    m_irdata);
            check("d_readdata",    bus.d_readdata,    m_drdata);
            check("i_busywait",    bus.i_busywait,    bus.i_read && !(in_done && !m_own_d));
            check("d_busywait",    bus.d_busywait,
                  (bus.d_read | bus.d_write) && !(in_done && m_own_d));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit gi, output bit gd);
        int n = 0;
        while ((bus.grant_i || bus.grant_d) && n < 50) begin tick(); n++; end
        while (!(bus.grant_i || bus.grant_d) && n < 50) begin tick(); n++; end
        gi = bus.grant_i;
        gd = bus.grant_d;
        check("grant_within_budget", n < 50, 1'b1);
    endtask

    task automatic wait_done(input bit is_d, output int at);
        at = -1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (is_d ? !bus.d_busywait : !bus.i_busywait) begin
                at = cyc;
                break;
            end
        end
        check("done_within_budget", at >= 0, 1'b1);
    endtask

    // Global watchdog so the run always ends with a summary.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int e0, at, rd, gr, n;
        bit gi, gd;

        reset = 1'b1;
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_writedata = '0;
        repeat (3) tick();
        check("reset_mem_read",  bus.mem_read, 1'b0);
        check("reset_grant_d",   bus.grant_d,  1'b0);
        check("reset_d_rdata",   bus.d_readdata, '0);
        reset = 1'b0;

        // Reset in the middle of a D write-back.
        mem_n = 4;
        bus.d_write = 1; bus.d_address = 28'h0000123;
        bus.d_writedata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        tick(); tick();
        check("rst_pre_mem_write", bus.mem_write, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_mem_write",  bus.mem_write,  1'b0);
        check("rst_grant_d",    bus.grant_d,    1'b0);
        check("rst_d_rdata",    bus.d_readdata, '0);
        check("rst_d_busywait", bus.d_busywait, 1'b1);
        check("rst_i_busywait", bus.i_busywait, 1'b0);
        check("rst_mem_addr",   bus.mem_address, '0);
        reset = 1'b0; bus.d_write = 0;
        tick();

        // Lone I read, N=4.
        mem_n = 4;
        mem_data = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        bus.i_read = 1; bus.i_address = 28'h0000010;
        e0 = cyc + 1; rd = 0; at = -1;
        for (int k = 0; k < 30 && at < 0; k++) begin
            tick();
            if (bus.mem_read) rd++;
            if (!bus.i_busywait) at = cyc;
        end
        check("lone_done_latency", at - e0, 5);
        check("lone_mem_read_cycles", rd, 5);
        check("lone_i_rdata", bus.i_readdata, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        check("lone_mem_addr", bus.mem_address, 28'h0000010);
        check("lone_d_rdata", bus.d_readdata, '0);
        bus.i_read = 0;
        tick();

        // Simultaneous I and D reads straight after reset: D wins the tie.
        reset = 1'b1; tick(); reset = 1'b0;
        mem_n = 2; mem_data = 128'hAAAA_0000_0000_0000_0000_0000_0000_0002;
        bus.i_read = 1; bus.i_address = 28'h0000001;
        bus.d_read = 1; bus.d_address = 28'h0000002;
        tick();
        check("tie_grant_d", bus.grant_d, 1'b1);
        check("tie_grant_i", bus.grant_i, 1'b0);
        check("tie_mem_addr", bus.mem_address, 28'h0000002);
        gi = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (!bus.i_busywait) gi = 1'b0;
            if (!bus.d_busywait) break;
            tick();
        end
        check("tie_i_stalled", gi, 1'b1);
        bus.d_read = 0;
        mem_data = 128'hBBBB_0000_0000_0000_0000_0000_0000_0001;
        tick();
        check("tie_idle_gap", bus.grant_i, 1'b0);
        tick();
        check("tie_then_i", bus.grant_i, 1'b1);
        check("tie_i_addr", bus.mem_address, 28'h0000001);
        wait_done(1'b0, at);
        bus.i_read = 0;
        tick();

        // Write-back, pending I read, then D refill: order D-write, I, D-read.
        mem_n = 3;
        bus.d_write = 1; bus.d_address = 28'h00000A0;
        bus.d_writedata = 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF;
        bus.i_read = 1; bus.i_address = 28'h0000040;
        wait_grant(gi, gd);
        check("wb_first_d", gd, 1'b1);
        check("wb_is_write", bus.mem_write, 1'b1);
        check("wb_wdata", bus.mem_writedata, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF);
        wait_done(1'b1, at);
        check("wb_wdata_held", bus.mem_writedata, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF);
        bus.d_write = 0; bus.d_read = 1; bus.d_address = 28'h00000B0;
        wait_grant(gi, gd);
        check("wb_second_i", gi, 1'b1);
        check("wb_i_addr", bus.mem_address, 28'h0000040);
        wait_done(1'b0, at);
        bus.i_read = 0;
        wait_grant(gi, gd);
        check("wb_third_d", gd, 1'b1);
        check("wb_third_read", bus.mem_read, 1'b1);
        check("wb_d_addr", bus.mem_address, 28'h00000B0);
        wait_done(1'b1, at);
        bus.d_read = 0;
        tick();

        // I request withdrawn two cycles into BUSY, N=3.
        mem_n = 3; mem_data = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        bus.i_read = 1; bus.i_address = 28'h0000077;
        wait_grant(gi, gd);
        rd = 0; gr = 0; n = 0;
        while (bus.grant_i && n < 20) begin
            if (bus.mem_read) rd++;
            gr++;
            if (n == 2) bus.i_read = 0;
            tick(); n++;
        end
        check("wd_mem_read_cycles", rd, 4);
        check("wd_grant_cycles", gr, 5);
        check("wd_i_rdata", bus.i_readdata, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC);

        // Memory already idle in the first BUSY cycle: still DONE at E0+2.
        mem_n = 1; mem_first_low = 1'b1;
        mem_data = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
        bus.d_read = 1; bus.d_address = 28'h0000055;
        e0 = cyc + 1;
        wait_done(1'b1, at);
        check("early_done_latency", at - e0, 2);
        check("early_d_rdata", bus.d_readdata, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
        bus.d_read = 0; mem_first_low = 1'b0;
        tick();

        // Randomized traffic; caches hold requests until their DONE cycle.
        for (int k = 0; k < 600; k++) begin
            tick();
            if (bus.i_read && !bus.i_busywait) bus.i_read = 0;
            else if (!bus.i_read && ($urandom % 3 == 0)) begin
                bus.i_read = 1; bus.i_address = ADDR_W'($urandom);
            end else if (bus.i_read && ($urandom % 60 == 0)) bus.i_read = 0;

            if ((bus.d_read || bus.d_write) && !bus.d_busywait) begin
                bus.d_read = 0; bus.d_write = 0;
            end else if (!(bus.d_read || bus.d_write) && ($urandom % 3 == 0)) begin
                bus.d_address = ADDR_W'($urandom);
                bus.d_writedata = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom % 3 == 0) bus.d_write = 1;
                else bus.d_read = 1;
                if ($urandom % 40 == 0) begin bus.d_read = 1; bus.d_write = 1; end
            end else if ((bus.d_read || bus.d_write) && ($urandom % 60 == 0)) begin
                bus.d_read = 0; bus.d_write = 0;
            end

            mem_n = int'($urandom_range(1, 5));
            mem_first_low = 1'($urandom % 2);
            mem_data = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom % 150 == 0);
        end
        reset = 0;
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        repeat (10) tick();
        check("never_both_cmds", both_seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit-block main memory between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between both cache controllers' memory-side ports and the main memory.
- Grants one block transaction at a time using round-robin priority, registers and holds the memory command for the whole transfer, and returns per-requester busywait and block read data.

Parameters:
- ADDR_W, 28, block address width (byte address [31:4]).
- BLOCK_W, 128, block data width.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  synchronous, active-high reset.
- I_READ  input  1  I-cache block read request.
- I_ADDRESS  input  ADDR_W  I-cache block address.
- I_READDATA  output  BLOCK_W  block returned to I-cache.
- I_BUSYWAIT  output  1  I-cache stall.
- D_READ  input  1  D-cache block read request.
- D_WRITE  input  1  D-cache block write-back request.
- D_ADDRESS  input  ADDR_W  D-cache block address.
- D_WRITEDATA  input  BLOCK_W  D-cache write-back block.
- D_READDATA  output  BLOCK_W  block returned to D-cache.
- D_BUSYWAIT  output  1  D-cache stall.
- MEM_READ  output  1  memory read command (registered).
- MEM_WRITE  output  1  memory write command (registered).
- MEM_ADDRESS  output  ADDR_W  memory block address (registered).
- MEM_WRITEDATA  output  BLOCK_W  memory write block (registered).
- MEM_READDATA  input  BLOCK_W  memory read block.
- MEM_BUSYWAIT  input  1  memory busy.
- GRANT_I  output  1  I-cache owns memory (debug).
- GRANT_D  output  1  D-cache owns memory (debug).

Behaviour:
- Reset: synchronous and active-high; sampled at posedge CLK.
  - STATE=IDLE; MEM_READ=MEM_WRITE=0; MEM_ADDRESS=0; MEM_WRITEDATA=0.
  - I_READDATA=D_READDATA=0; GRANT_I=GRANT_D=0; LAST_OWNER=I.
  - Reset mid-transaction aborts it immediately. Memory is reset by the same RESET.
- Requests: I_REQ=I_READ; D_REQ=D_READ|D_WRITE.
  - D_READ and D_WRITE together is illegal; the write takes precedence.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesters: grant the one that is not LAST_OWNER. After reset, D wins the first tie.
  - On grant, at the same edge:
    - Latch the owner and set GRANT_x.
    - Latch the address, plus write data for a D write.
    - Set MEM_READ or MEM_WRITE.
    - Set FIRST=1; go to BUSY.
- BUSY:
  - Command, address and data are held stable.
  - In the first cycle (FIRST=1), MEM_BUSYWAIT is ignored; clear FIRST.
  - After that, at the first edge with MEM_BUSYWAIT=0:
    - For a read, capture MEM_READDATA into the owner's READDATA register.
    - Clear MEM_READ and MEM_WRITE; LAST_OWNER<=owner; go to DONE.
- DONE:
  - Owner's BUSYWAIT is low for exactly this cycle. READDATA is valid from DONE and held until that requester's next read completes.
  - Next edge: go to IDLE and clear GRANT_x. There is always at least one IDLE cycle between transactions.
- BUSYWAIT (combinational):
  - I_BUSYWAIT = I_REQ & !(STATE==DONE & owner==I).
  - D_BUSYWAIT is the same with D.
  - A non-owner with a pending request sees busywait high throughout.
- Request withdrawn during BUSY: the transaction still runs to completion (memory cannot abort). DONE still occurs; the READDATA update still occurs.
- Write-back then refill: the D-cache issues write then read as two grants. An I request pending during the write wins the next grant (round robin). The D-cache must hold D_READ and wait.
- Latency, with memory busy for N cycles after command, N≥1:
  - Request at edge E0 → DONE at E0+N+1.
  - Back-to-back from the same requester costs one more cycle (IDLE).
- The arbiter never issues MEM_READ and MEM_WRITE together.

Test Plan:
- Reset mid-BUSY (D write to 0x0000123) → next cycle MEM_WRITE=0, STATE=IDLE, GRANT_D=0, D_READDATA=0, both BUSYWAITs follow their requests.
- Lone I read, address 0x0000010, memory N=4 returning 0x0011…FF → MEM_READ 1 for 5 cycles, MEM_ADDRESS=0x0000010. I_BUSYWAIT drops one cycle at E0+5 with I_READDATA=0x0011…FF. D_READDATA unchanged.
- Simultaneous I read 0x0000001 and D read 0x0000002 after reset → D granted first. I_BUSYWAIT stays high through the D transfer. I granted after one IDLE cycle, MEM_ADDRESS=0x0000001.
- D write-back 0x00000A0 with data 0xDEAD…BEEF, then D read 0x00000B0, while an I read is pending → order: D write, I read, D read. MEM_WRITEDATA is stable during the write. MEM_READ and MEM_WRITE are never both 1.
- I request withdrawn two cycles into BUSY (N=3) → MEM_READ held until MEM_BUSYWAIT=0, DONE occurs, I_READDATA updated, then IDLE.
- Memory with MEM_BUSYWAIT low in the first BUSY cycle → arbiter ignores it, waits one more edge; DONE no earlier than E0+2.
